prog_mem_ctrl: RTL
==================

Name: prog_mem_ctrl

Overview:
- Owns the single port of the program memory and shares it between two users: the CPU fetch unit and a byte-serial program loader (UART/debug side).
- Fetch has the port by default.
- A load session takes the port exclusively, packs incoming bytes into DATA_SIZE words, and writes them sequentially from a start address. During the session it holds the CPU in stall.

Parameters:
- DATA_SIZE, 16, program word width; must be a multiple of 8; BPW = DATA_SIZE/8 bytes per word.
- ADDR_SIZE, 4, program memory address width; depth 2**ADDR_SIZE.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- fetch_req  in  1  CPU requests a read this cycle.
- fetch_addr  in  ADDR_SIZE  read address.
- fetch_gnt  out  1  request accepted this cycle (combinational).
- fetch_valid  out  1  fetch_data valid (cycle after grant).
- fetch_data  out  DATA_SIZE  read word (mem_data passthrough).
- cpu_hold  out  1  stall CPU; equals ld_busy.
- ld_start  in  1  start a load session (pulse).
- ld_base  in  ADDR_SIZE  first write address, latched on start.
- ld_len  in  ADDR_SIZE+1  word count, latched on start; 0..2**ADDR_SIZE.
- ld_valid  in  1  ld_byte valid.
- ld_byte  in  8  program byte, little-endian within word.
- ld_ready  out  1  controller accepts a byte this cycle.
- ld_busy  out  1  load session active.
- ld_done  out  1  one-cycle pulse, session complete.
- ld_err  out  1  checksum error, sticky until next ld_start (optional feature only).
- mem_w  out  1  memory write strobe.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_data_wr  out  DATA_SIZE  memory write data.
- mem_data  in  DATA_SIZE  memory registered read data; memory updates it one cycle after a non-write cycle.

Behaviour:
- Reset (rst=1 at a clk edge): state RUN; wr_ptr, words_left, byte_cnt and assembly register cleared.
- Registered outputs reset to 0: fetch_valid, ld_ready, ld_busy, ld_done, ld_err, mem_w.
- Reset mid-session: abort immediately. Memory keeps the words already written; no ld_done.
- States: RUN, COLLECT, WRITE, CHECK (optional feature only), DONE.
- RUN:
  - fetch_gnt = fetch_req & ~ld_start; mem_addr = fetch_addr; mem_w = 0.
  - fetch_valid registered = fetch_gnt; data returns one cycle after grant.
  - Back-to-back fetches supported at one per cycle.
- RUN, ld_start=1:
  - Latch ld_base into wr_ptr and ld_len into words_left; ld_start has priority, so fetch_gnt=0 that cycle.
  - ld_len≠0: go to COLLECT.
  - ld_len=0: go to CHECK if the feature is enabled, else DONE. No writes.
- ld_start outside RUN: ignored.
- COLLECT:
  - ld_ready=1; fetch_gnt=0; mem_w=0.
  - Byte accepted when ld_valid & ld_ready, into byte lane byte_cnt (lane 0 = bits 7:0); byte_cnt increments.
  - On the BPW-th byte: byte_cnt clears; go to WRITE.
- WRITE (exactly 1 cycle):
  - ld_ready=0; mem_w=1; mem_addr=wr_ptr; mem_data_wr=assembled word.
  - Then wr_ptr+1 (wraps modulo 2**ADDR_SIZE) and words_left-1.
  - words_left becomes 0: go to CHECK if the feature is enabled, else DONE. Otherwise go to COLLECT.
- DONE: ld_done=1 for one cycle; go to RUN.
- ld_busy=1 in COLLECT, WRITE, CHECK and DONE.
- Throughput: one word per BPW+1 cycles minimum (BPW accepts + 1 write). ld_valid gaps are tolerated without limit.
- mem_addr in non-RUN, non-WRITE states = wr_ptr; mem_data_wr = assembled word at all times.
- fetch_data = mem_data always. Consumers sample only on fetch_valid.
- The write cycle does not disturb the memory read register. After a session, the first fetch returns fresh data one cycle after grant.

Optional Feature:
- Macro: PROG_MEM_CTRL_CHECKSUM_EN.
- Defined:
  - An 8-bit sum of all accepted data bytes is cleared on ld_start.
  - After the last word, CHECK asserts ld_ready for one extra byte; on accept, ld_err = ((sum + byte) & 8'hFF) ≠ 0; then go to DONE.
  - ld_err is cleared on ld_start and on reset.
- Undefined: CHECK does not exist; ld_err tied to 0.

Test Plan:
- Reset then fetch: fetch_req=1, addr=3 at cycle N -> fetch_gnt=1 at N; fetch_valid=1 at N+1 with fetch_data=0. ld_busy=0, mem_w=0.
- Load 2 words: ld_start, base=2, len=2; bytes 34,12,CD,AB -> mem_w pulses with (2,16'h1234) then (3,16'hABCD); ld_done one cycle later; fetch addr 3 returns 16'hABCD.
- Wrap plus stalls: base=15, len=2, ld_valid toggling 1/0 -> writes to addr 15 then 0; ld_ready=0 during each WRITE cycle; cpu_hold=1 throughout the session.
- Contention: fetch_req=1 and ld_start=1 in the same cycle -> fetch_gnt=0, no fetch_valid next cycle; fetch_req during COLLECT -> fetch_gnt=0.
- Edge cases:
  - len=0 -> ld_done 1 cycle after start, no mem_w.
  - rst after 1 of 2 words -> ld_busy=0 next cycle, word 1 retained, no ld_done.
  - ld_start during COLLECT -> ignored.
- CHECKSUM_EN: bytes 34,12 then check byte BA -> ld_err=0; same words with check byte 00 -> ld_err=1, still ld_done; next ld_start clears ld_err.

Source files
------------

// File: rtl/prog_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_ctrl_if
// Description : Bundles the fetch, loader and memory-side signals of
//               prog_mem_ctrl. The slave modport is the controller's view;
//               the master modport is the surrounding environment
//               (CPU fetch unit, byte loader, program memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_mem_ctrl_if #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4
);
    // CPU fetch side
    logic                 fetch_req;
    logic [ADDR_SIZE-1:0] fetch_addr;
    logic                 fetch_gnt;
    logic                 fetch_valid;
    logic [DATA_SIZE-1:0] fetch_data;
    logic                 cpu_hold;
    // byte-serial loader side
    logic                 ld_start;
    logic [ADDR_SIZE-1:0] ld_base;
    logic [ADDR_SIZE:0]   ld_len;
    logic                 ld_valid;
    logic [7:0]           ld_byte;
    logic                 ld_ready;
    logic                 ld_busy;
    logic                 ld_done;
    logic                 ld_err;
    // program memory port
    logic                 mem_w;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_data_wr;
    logic [DATA_SIZE-1:0] mem_data;

    modport slave (
        input  fetch_req, fetch_addr, ld_start, ld_base, ld_len,
               ld_valid, ld_byte, mem_data,
        output fetch_gnt, fetch_valid, fetch_data, cpu_hold, ld_ready,
               ld_busy, ld_done, ld_err, mem_w, mem_addr, mem_data_wr
    );

    modport master (
        output fetch_req, fetch_addr, ld_start, ld_base, ld_len,
               ld_valid, ld_byte, mem_data,
        input  fetch_gnt, fetch_valid, fetch_data, cpu_hold, ld_ready,
               ld_busy, ld_done, ld_err, mem_w, mem_addr, mem_data_wr
    );
endinterface
`default_nettype wire

// File: rtl/prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_ctrl
// Description : Single-port program memory arbiter. CPU fetch owns the port
//               by default; a load session takes it exclusively, packs
//               little-endian bytes into words and writes them sequentially
//               from a base address while holding the CPU.
//               Optional checksum byte: define PROG_MEM_CTRL_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_ctrl #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    prog_mem_ctrl_if.slave   bus
);
    localparam int BPW   = DATA_SIZE / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
        ST_CHECK   = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_t;

    state_t               state_q,       state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q,      wr_ptr_d;
    logic [ADDR_SIZE:0]   words_left_q,  words_left_d;
    logic [CNT_W-1:0]     byte_cnt_q,    byte_cnt_d;
    logic [DATA_SIZE-1:0] asm_q,         asm_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic                 ld_ready_q,    ld_ready_d;
    logic                 ld_busy_q,     ld_busy_d;
    logic                 ld_done_q,     ld_done_d;
    logic                 mem_w_q,       mem_w_d;
    logic                 gnt;
    logic [ADDR_SIZE-1:0] addr_sel;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
    logic [7:0]           sum_q,         sum_d;
    logic                 ld_err_q,      ld_err_d;
    logic [7:0]           sum_plus;
`endif

    // Next-state, datapath updates and port-arbitration decode
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        gnt          = 1'b0;
        addr_sel     = wr_ptr_q;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
        sum_d        = sum_q;
        ld_err_d     = ld_err_q;
        sum_plus     = sum_q + bus.ld_byte;
`endif
        case (state_q)
            ST_RUN: begin
                addr_sel = bus.fetch_addr;
                // a starting session wins over a same-cycle fetch
                gnt      = bus.fetch_req & ~bus.ld_start;
                if (bus.ld_start) begin
                    wr_ptr_d     = bus.ld_base;
                    words_left_d = bus.ld_len;
                    byte_cnt_d   = '0;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
                    sum_d        = 8'h00;
                    ld_err_d     = 1'b0;
`endif
                    if (bus.ld_len != '0) begin
                        state_d = ST_COLLECT;
                    end else begin
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.ld_valid && ld_ready_q) begin
                    for (int i = 0; i < BPW; i++) begin
                        if (byte_cnt_q == CNT_W'(i)) begin
                            asm_d[i*8 +: 8] = bus.ld_byte;
                        end
                    end
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
                    sum_d = sum_plus;
`endif
                    if (byte_cnt_q == CNT_W'(BPW - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                wr_ptr_d     = wr_ptr_q + ADDR_SIZE'(1);
                words_left_d = words_left_q - (ADDR_SIZE+1)'(1);
                if (words_left_q == (ADDR_SIZE+1)'(1)) begin
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
            ST_CHECK: begin
                // trailing byte makes the running byte sum wrap to zero
                if (bus.ld_valid && ld_ready_q) begin
                    ld_err_d = (sum_plus != 8'h00);
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // status outputs are registered copies of what the next state implies
        fetch_valid_d = gnt;
        ld_busy_d     = (state_d != ST_RUN);
        mem_w_d       = (state_d == ST_WRITE);
        ld_done_d     = (state_d == ST_DONE);
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
        ld_ready_d    = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
`else
        ld_ready_d    = (state_d == ST_COLLECT);
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= '0;
            words_left_q  <= '0;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            fetch_valid_q <= 1'b0;
            ld_ready_q    <= 1'b0;
            ld_busy_q     <= 1'b0;
            ld_done_q     <= 1'b0;
            mem_w_q       <= 1'b0;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
            sum_q         <= 8'h00;
            ld_err_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            words_left_q  <= words_left_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            fetch_valid_q <= fetch_valid_d;
            ld_ready_q    <= ld_ready_d;
            ld_busy_q     <= ld_busy_d;
            ld_done_q     <= ld_done_d;
            mem_w_q       <= mem_w_d;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
            sum_q         <= sum_d;
            ld_err_q      <= ld_err_d;
`endif
        end
    end

    assign bus.fetch_gnt   = gnt;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = bus.mem_data;
    assign bus.cpu_hold    = ld_busy_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_busy     = ld_busy_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.mem_w       = mem_w_q;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_data_wr = asm_q;
`ifdef PROG_MEM_CTRL_CHECKSUM_EN
    assign bus.ld_err      = ld_err_q;
`else
    assign bus.ld_err      = 1'b0;
`endif

endmodule
`default_nettype wire
